adc_uart_scanner: RTL and testbench
===================================

Name: adc_uart_scanner

Overview:
- Parametrised successor of the ADC-scan / serial-transmit controller.
- Sequences an external multiplexed ADC over NUM_CH channels and captures each DATA_W-bit conversion.
- Sends each capture as an asynchronous serial frame with configurable bit period and optional parity.
- Adds a real per-bit baud timer, channel wrap at NUM_CH, a dsr-gated send with error flag, and asynchronous reset.

Parameters:
NUM_CH, 8, number of scanned channels (2..2**CH_W)
CH_W, 3, width of canale
DATA_W, 8, conversion width / frame data bits (4..16)
DIV, 105, clock cycles per serial bit (>=2)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
eoc  in  1  ADC end-of-conversion; low = result ready
data_in  in  DATA_W  ADC result
dsr  in  1  receiver ready; sampled at frame start
soc  out  1  start-of-conversion
load_dato  out  1  one-cycle pulse when data_in is captured
mux_en  out  1  analog mux enable
canale  out  CH_W  channel currently being converted
data_out  out  1  serial line, idle high
tx_end  out  1  one-cycle pulse in the last cycle of the stop bit
error  out  1  sticky-until-next-good-frame dsr error
busy  out  1  transmitter active

Behaviour:
- Reset (async, any time, including mid-frame): soc=0, load_dato=0, mux_en=0, canale=0, data_out=1, tx_end=0, error=0, busy=0.
- Reset also clears: scan FSM to S_MUX, TX FSM to T_IDLE, baud counter=0, bit index=0, sample register=0.
- Scan FSM, one state per cycle unless noted:
  - S_MUX: mux_en=1 -> S_SETTLE.
  - S_SETTLE -> S_SOC.
  - S_SOC: soc=1 -> S_WAIT.
  - S_WAIT: while eoc=1, stay. On eoc=0: sample<=data_in, load_dato=1 for exactly this cycle, mux_en=0, soc=0 -> S_REQ.
  - S_REQ: raise internal tx request; canale <= (canale==NUM_CH-1) ? 0 : canale+1 -> S_HOLD.
  - S_HOLD: wait for tx_end or drop; then -> S_MUX in the next cycle.
- canale always changes in S_REQ only and never exceeds NUM_CH-1.
- TX FSM:
  - T_IDLE, request seen: if dsr=0 -> error=1, frame dropped, drop acknowledged same cycle, stay T_IDLE. If dsr=1 -> error=0, busy=1, shift reg<=sample -> T_START.
  - T_START: data_out=0 for DIV cycles.
  - T_DATA: DATA_W bits, MSB first, each held DIV cycles.
  - T_PAR (only if PARITY_EN): bit = XOR of data, inverted when PARITY_ODD; held DIV cycles.
  - T_STOP: data_out=1 for DIV cycles; tx_end=1 in the final cycle; busy=0 from the next cycle -> T_IDLE.
- Baud counter counts 0..DIV-1 and wraps on each bit boundary. Width is clog2(DIV); no overflow is possible.
- The first frame bit appears on data_out the cycle after acceptance.
- Frame length: (1+DATA_W+PARITY_EN+1)*DIV cycles.
- dsr is ignored after frame acceptance. Deasserting dsr mid-frame has no effect.
- A new request cannot occur while busy (scan waits in S_HOLD), so no overrun path exists.
- Invariants:
  - load_dato=1 implies mux_en=0.
  - tx_end=1 implies error=0.
  - error=1 implies busy=0.

Test Plan:
- DIV=4, DATA_W=8, NUM_CH=8, dsr=1, eoc drops 2 cycles after soc, data_in=8'hA5 -> load_dato single pulse; data_out = 0,1,0,1,0,0,1,0,1,1 each for 4 cycles; tx_end pulse on cycle 40 of frame; canale=1.
- NUM_CH=3, eoc=0 always, dsr=1 -> canale sequence 1,2,0,1; never 3.
- dsr=0 at request -> error=1, data_out stays 1, no tx_end. Scan restarts; next request with dsr=1 -> error=0 at acceptance.
- PARITY_EN=1, PARITY_ODD=0, data_in=8'h07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 11*DIV cycles.
- eoc held 1 for 50 cycles -> soc=1, mux_en=1, load_dato=0 throughout. Capture occurs the cycle eoc falls.
- reset asserted mid-T_DATA -> data_out=1, busy=0, canale=0 immediately (no clock edge needed). After release, the scan restarts at S_MUX.

Source files
------------

// File: rtl/adc_uart_scanner.sv
// ADC scan sequencer feeding an asynchronous serial transmitter.
// Each captured conversion is sent as one frame; a receiver that is not ready drops the frame and flags error.
//
// state    | meaning
// S_MUX    | enable analog mux for current channel
// S_SETTLE | one cycle of mux settling
// S_SOC    | start conversion
// S_WAIT   | hold soc until eoc falls, then capture
// S_REQ    | post transmit request, advance channel
// S_HOLD   | wait for frame end or drop
// T_IDLE   | line idle, waiting for a request
// T_START  | start bit
// T_DATA   | data bits, MSB first
// T_PAR    | optional parity bit
// T_STOP   | stop bit
module adc_uart_scanner #(
    parameter int NUM_CH     = 8,
    parameter int CH_W       = 3,
    parameter int DATA_W     = 8,
    parameter int DIV        = 105,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              soc,
    output logic              load_dato,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              data_out,
    output logic              tx_end,
    output logic              error,
    output logic              busy
);

    localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_MUX, S_SETTLE, S_SOC, S_WAIT, S_REQ, S_HOLD
    } scan_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    scan_state_t scan_state, scan_next;
    tx_state_t   tx_state, tx_next;

    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] shift_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              par_bit;
    logic              req_pend;
    logic              error_r;

    logic mux_c, soc_c, load_c;
    logic accept_c, drop_c, tx_end_c, data_c;
    logic baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        scan_next = scan_state;
        mux_c     = 1'b0;
        soc_c     = 1'b0;
        load_c    = 1'b0;
        case (scan_state)
            S_MUX: begin
                mux_c     = 1'b1;
                scan_next = S_SETTLE;
            end
            S_SETTLE: begin
                mux_c     = 1'b1;
                scan_next = S_SOC;
            end
            S_SOC: begin
                mux_c     = 1'b1;
                soc_c     = 1'b1;
                scan_next = S_WAIT;
            end
            S_WAIT: begin
                if (eoc) begin
                    mux_c = 1'b1;
                    soc_c = 1'b1;
                end else begin
                    load_c    = 1'b1;
                    scan_next = S_REQ;
                end
            end
            S_REQ:   scan_next = S_HOLD;
            S_HOLD: begin
                if (tx_end_c || drop_c)
                    scan_next = S_MUX;
            end
            default: scan_next = S_MUX;
        endcase
    end

    // Scan strobes are decoded from state; gating with reset keeps them low while reset is held.
    assign mux_en    = mux_c  & ~reset;
    assign soc       = soc_c  & ~reset;
    assign load_dato = load_c & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_state <= S_MUX;
            sample     <= '0;
            canale     <= '0;
            req_pend   <= 1'b0;
        end else begin
            scan_state <= scan_next;
            if (load_c)
                sample <= data_in;
            if (scan_state == S_REQ) begin
                canale   <= (canale == CH_LAST) ? '0 : canale + CH_W'(1);
                req_pend <= 1'b1;
            end else if (accept_c || drop_c) begin
                req_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_next  = tx_state;
        accept_c = 1'b0;
        drop_c   = 1'b0;
        tx_end_c = 1'b0;
        data_c   = 1'b1;
        case (tx_state)
            T_IDLE: begin
                if (req_pend) begin
                    if (dsr) begin
                        accept_c = 1'b1;
                        tx_next  = T_START;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
            end
            T_START: begin
                data_c = 1'b0;
                if (baud_done)
                    tx_next = T_DATA;
            end
            T_DATA: begin
                data_c = shift_reg[DATA_W-1];
                if (baud_done && (bit_idx == IDX_LAST))
                    tx_next = (PARITY_EN != 0) ? T_PAR : T_STOP;
            end
            T_PAR: begin
                data_c = par_bit;
                if (baud_done)
                    tx_next = T_STOP;
            end
            T_STOP: begin
                if (baud_done) begin
                    tx_end_c = 1'b1;
                    tx_next  = T_IDLE;
                end
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state  <= T_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (accept_c) begin
                baud_cnt  <= '0;
                bit_idx   <= '0;
                shift_reg <= sample;
                par_bit   <= (^sample) ^ PAR_ODD;
                error_r   <= 1'b0;
            end else if (drop_c) begin
                error_r <= 1'b1;
            end else if (tx_state != T_IDLE) begin
                if (baud_done) begin
                    baud_cnt <= '0;
                    if (tx_state == T_DATA) begin
                        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        bit_idx   <= bit_idx + IDX_W'(1);
                    end
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
            end
        end
    end

    assign data_out = data_c;
    assign tx_end   = tx_end_c;
    assign busy     = (tx_state != T_IDLE);
    assign error    = error_r;

endmodule

// File: tb/tb_adc_uart_scanner.sv
// Directed bench for adc_uart_scanner: one plain instance plus even/odd parity instances.
module tb_adc_uart_scanner;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, rst_p;
    logic       eoc, dsr;
    logic [7:0] data_in;
    logic       soc, load_dato, mux_en, data_out, tx_end, error, busy;
    logic [2:0] canale;

    logic       eoc_p = 1'b0;
    logic       dsr_p = 1'b1;
    logic [7:0] data_p = 8'h07;
    logic       p_soc, p_load, p_mux, p_dout, p_tx_end, p_error, p_busy;
    logic [1:0] p_canale;
    logic       o_soc, o_load, o_mux, o_dout, o_tx_end, o_error, o_busy;
    logic [1:0] o_canale;

    int n_checks = 0;
    int n_fail   = 0;
    int ch_over  = 0;

    adc_uart_scanner #(.NUM_CH(8), .CH_W(3), .DATA_W(8), .DIV(4),
                       .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
        .soc(soc), .load_dato(load_dato), .mux_en(mux_en), .canale(canale),
        .data_out(data_out), .tx_end(tx_end), .error(error), .busy(busy));

    adc_uart_scanner #(.NUM_CH(3), .CH_W(2), .DATA_W(8), .DIV(4),
                       .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clock(clock), .reset(rst_p), .eoc(eoc_p), .data_in(data_p), .dsr(dsr_p),
        .soc(p_soc), .load_dato(p_load), .mux_en(p_mux), .canale(p_canale),
        .data_out(p_dout), .tx_end(p_tx_end), .error(p_error), .busy(p_busy));

    adc_uart_scanner #(.NUM_CH(3), .CH_W(2), .DATA_W(8), .DIV(4),
                       .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clock(clock), .reset(rst_p), .eoc(eoc_p), .data_in(data_p), .dsr(dsr_p),
        .soc(o_soc), .load_dato(o_load), .mux_en(o_mux), .canale(o_canale),
        .data_out(o_dout), .tx_end(o_tx_end), .error(o_error), .busy(o_busy));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock)
        if (!rst_p && (p_canale >= 2'd3 || o_canale >= 2'd3))
            ch_over++;

    initial begin
        int n, bad, bad_o, ends, endpos, par_e, par_o;
        logic [9:0]  exp_a5;
        logic [10:0] exp_even, exp_odd;
        int exp_ch[3];
        exp_a5   = {1'b0, 8'hA5, 1'b1};
        exp_even = {1'b0, 8'h07, 1'b1, 1'b1};
        exp_odd  = {1'b0, 8'h07, 1'b0, 1'b1};
        exp_ch   = '{2, 0, 1};

        reset = 1'b1; rst_p = 1'b1; eoc = 1'b1; dsr = 1'b1; data_in = 8'hA5;
        repeat (3) @(negedge clock);
        check_val("rst_soc",      32'(soc), 0);
        check_val("rst_load",     32'(load_dato), 0);
        check_val("rst_mux",      32'(mux_en), 0);
        check_val("rst_canale",   32'(canale), 0);
        check_val("rst_data_out", 32'(data_out), 1);
        check_val("rst_tx_end",   32'(tx_end), 0);
        check_val("rst_error",    32'(error), 0);
        check_val("rst_busy",     32'(busy), 0);
        reset = 1'b0;

        // Long conversion: strobes hold while eoc stays high.
        n = 0;
        while (!soc && n < 10) begin @(negedge clock); n++; end
        check_val("soc_rise", 32'(soc), 1);
        bad = 0;
        repeat (50) begin
            if (!(soc && mux_en && !load_dato)) bad++;
            @(negedge clock);
        end
        check_val("eoc_hold", bad, 0);
        eoc = 1'b0; #1;
        check_val("cap_load", 32'(load_dato), 1);
        check_val("cap_mux",  32'(mux_en), 0);
        check_val("cap_soc",  32'(soc), 0);
        @(negedge clock); eoc = 1'b1;
        check_val("load_pulse_end", 32'(load_dato), 0);
        @(negedge clock);
        check_val("pre_accept_busy", 32'(busy), 0);
        check_val("canale_1",        32'(canale), 1);
        @(negedge clock);
        check_val("accept_busy",  32'(busy), 1);
        check_val("accept_error", 32'(error), 0);
        bad = 0; ends = 0; endpos = -1;
        for (int i = 0; i < 40; i++) begin
            if (data_out !== exp_a5[9 - i/4]) bad++;
            if (tx_end) begin ends++; endpos = i; end
            if (i < 39) @(negedge clock);
        end
        check_val("frame_a5_bits", bad, 0);
        check_val("tx_end_count",  ends, 1);
        check_val("tx_end_pos",    endpos, 39);
        @(negedge clock);
        check_val("post_busy",   32'(busy), 0);
        check_val("post_tx_end", 32'(tx_end), 0);
        check_val("rescan_mux",  32'(mux_en), 1);

        // Receiver not ready: frame dropped, error sticky.
        dsr = 1'b0; data_in = 8'h3C;
        n = 0;
        while (!soc && n < 10) begin @(negedge clock); n++; end
        check_val("soc_rise_2", 32'(soc), 1);
        repeat (2) @(negedge clock);
        eoc = 1'b0;
        @(negedge clock); eoc = 1'b1;
        @(negedge clock);
        check_val("pre_drop_error", 32'(error), 0);
        check_val("canale_2",       32'(canale), 2);
        @(negedge clock);
        check_val("drop_error",    32'(error), 1);
        check_val("drop_busy",     32'(busy), 0);
        check_val("drop_data_out", 32'(data_out), 1);
        bad = 0;
        repeat (12) begin
            if (!data_out || tx_end || busy || !error) bad++;
            @(negedge clock);
        end
        check_val("idle_after_drop", bad, 0);

        dsr = 1'b1; data_in = 8'h00;
        n = 0;
        while (!soc && n < 10) begin @(negedge clock); n++; end
        check_val("soc_rise_3", 32'(soc), 1);
        repeat (2) @(negedge clock);
        eoc = 1'b0;
        @(negedge clock); eoc = 1'b1;
        @(negedge clock);
        check_val("error_sticky", 32'(error), 1);
        @(negedge clock);
        check_val("error_cleared", 32'(error), 0);
        check_val("busy_3",        32'(busy), 1);
        check_val("canale_3",      32'(canale), 3);

        // Asynchronous reset in the middle of the data bits.
        repeat (9) @(negedge clock);
        check_val("mid_data_low", 32'(data_out), 0);
        #2 reset = 1'b1; #1;
        check_val("ar_data_out", 32'(data_out), 1);
        check_val("ar_busy",     32'(busy), 0);
        check_val("ar_canale",   32'(canale), 0);
        check_val("ar_mux",      32'(mux_en), 0);
        @(negedge clock); reset = 1'b0; #1;
        check_val("restart_mux", 32'(mux_en), 1);
        check_val("restart_soc", 32'(soc), 0);
        @(negedge clock);
        check_val("settle_soc", 32'(soc), 0);
        @(negedge clock);
        check_val("soc_state", 32'(soc), 1);

        // Parity instances, eoc tied low: frames back to back.
        rst_p = 1'b0;
        n = 0;
        while (!p_busy && n < 20) begin @(negedge clock); n++; end
        check_val("par_busy_rise", 32'(p_busy), 1);
        bad = 0; bad_o = 0; endpos = -1; par_e = -1; par_o = -1;
        for (int i = 0; i < 44; i++) begin
            if (p_dout !== exp_even[10 - i/4]) bad++;
            if (o_dout !== exp_odd[10 - i/4]) bad_o++;
            if (i == 38) begin par_e = 32'(p_dout); par_o = 32'(o_dout); end
            if (p_tx_end) endpos = i;
            if (i < 43) @(negedge clock);
        end
        check_val("frame_even",     bad, 0);
        check_val("frame_odd",      bad_o, 0);
        check_val("parity_even",    par_e, 1);
        check_val("parity_odd",     par_o, 0);
        check_val("par_tx_end_pos", endpos, 43);
        check_val("par_canale_1",   32'(p_canale), 1);
        @(negedge clock);
        check_val("par_busy_end", 32'(p_busy), 0);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!p_tx_end && n < 100) begin @(negedge clock); n++; end
            check_val("par_tx_end_seen", 32'(p_tx_end), 1);
            check_val("par_canale_seq",  32'(p_canale), exp_ch[k]);
            @(negedge clock);
        end
        check_val("canale_bound", ch_over, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
